// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: write-port controller for the 8 x 8-bit register file.
// Shares one write path between N_REQ requesters with round-robin arbitration
// and a valid/ready handshake, turning each accepted write into a one-cycle
// one-hot register enable plus data. After reset or clr it walks every
// register once, writing INIT_VAL.
// Optional feature macro: REGARB_R0_ZERO_EN (r0 acts as a constant-zero
// register and err_r0 flags attempted writes to it).

module regfile_write_arbiter #(
  parameter int                N_REQ    = 3,
  parameter int                DATA_W   = 8,
  parameter int                N_REG    = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    stall,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [3*N_REQ-1:0]      req_addr,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REG-1:0]        wr_en,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    busy,
  output logic                    err_r0
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t            state;
  logic [2:0]        idx;
  logic [2:0]        ptr;
  logic [2:0]        win;
  logic [2:0]        cand;
  logic              found;
  logic [7:0]        valid_ext;
  logic [2:0]        win_addr;
  logic [DATA_W-1:0] win_data;
  logic [DATA_W-1:0] init_data;
  logic              r0_hit;

  // Zero-extend the request vector so a 3-bit candidate index always fits.
  assign valid_ext = 8'(req_valid);

  // Round-robin scan starting at ptr; the first valid requester wins.
  // clr and stall both suppress the grant, and nothing is granted in INIT.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    cand  = 3'd0;
    if (state == RUN && !clr && !stall) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = ptr + 3'(k);
        if (cand >= 3'(N_REQ)) begin
          cand = cand - 3'(N_REQ);
        end
        if (!found && valid_ext[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  // Turn the winner index into the one-hot ready vector.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = found && (win == 3'(i));
    end
  end

  assign win_addr = req_addr[int'(win)*3 +: 3];
  assign win_data = req_data[int'(win)*DATA_W +: DATA_W];

`ifdef REGARB_R0_ZERO_EN
  // r0 is hard-wired to zero: init writes 0 there and run-time writes are masked.
  assign init_data = (idx == 3'd0) ? '0 : INIT_VAL;
  assign r0_hit    = (win_addr == 3'd0);
`else
  // r0 is an ordinary register.
  assign init_data = INIT_VAL;
  assign r0_hit    = 1'b0;
`endif

  assign busy = (state == INIT);

  // Control FSM plus registered write stage: clr beats stall beats requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= INIT;
      idx     <= 3'd0;
      ptr     <= 3'd0;
      wr_en   <= '0;
      wr_data <= '0;
    end else if (clr) begin
      state <= INIT;
      idx   <= 3'd0;
      wr_en <= '0;
    end else if (state == INIT) begin
      wr_en   <= N_REG'(1) << idx;
      wr_data <= init_data;
      if (idx == 3'(N_REG - 1)) begin
        state <= RUN;
        idx   <= 3'd0;
      end else begin
        idx <= idx + 3'd1;
      end
    end else if (found) begin
      wr_en   <= r0_hit ? '0 : (N_REG'(1) << win_addr);
      wr_data <= win_data;
      ptr     <= (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
    end else begin
      wr_en <= '0;
    end
  end

`ifdef REGARB_R0_ZERO_EN
  logic err_q;

  // Sticky r0-write flag, cleared only by reset or clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (clr) begin
      err_q <= 1'b0;
    end else if (found && r0_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_r0 = err_q;
`else
  assign err_r0 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with
// literal expectations, then randomized traffic checked every cycle against
// a behavioural model of the arbiter.

module tb_regfile_write_arbiter;

  localparam int         NR = 3;
  localparam logic [7:0] IV = 8'hA5;
`ifdef REGARB_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] req_valid = '0;
  logic [8:0] req_addr = '0;
  logic [23:0] req_data = '0;
  logic [2:0] req_ready;
  logic [7:0] wr_en;
  logic [7:0] wr_data;
  logic       busy;
  logic       err_r0;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  bit         m_busy;
  int         m_idx;
  int         m_ptr;
  logic [7:0] m_wr_en;
  logic [7:0] m_wr_data;
  bit         m_err;
  logic [2:0] m_ready;
  logic [2:0] last_grant;

  // Random requester bookkeeping
  logic [2:0] p_valid;
  logic [2:0] p_addr [3];
  logic [7:0] p_data [3];

  regfile_write_arbiter #(
    .N_REQ(3), .DATA_W(8), .N_REG(8), .INIT_VAL(IV)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .err_r0(err_r0)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_busy = 1'b1; m_idx = 0; m_ptr = 0;
    m_wr_en = '0; m_wr_data = '0; m_err = 1'b0; m_ready = '0;
    last_grant = '0;
  endtask

  // Grant rule: first valid requester scanning from ptr, none when busy/clr/stall
  task automatic computeReady();
    bit got;
    got = 1'b0;
    m_ready = '0;
    if (!m_busy && !clr && !stall && reset) begin
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (!got && req_valid[j]) begin
          got = 1'b1;
          m_ready[j] = 1'b1;
        end
      end
    end
  endtask

  // Effect of one rising edge on the model, using the inputs held before it
  task automatic modelStep();
    if (clr) begin
      m_wr_en = '0; m_busy = 1'b1; m_idx = 0; m_err = 1'b0;
    end else if (m_busy) begin
      m_wr_en = 8'd1 << m_idx;
      m_wr_data = (R0Z && m_idx == 0) ? 8'h00 : IV;
      m_idx++;
      if (m_idx == 8) begin
        m_busy = 1'b0; m_idx = 0;
      end
    end else if (m_ready != 0) begin
      int w;
      logic [2:0] a;
      w = 0;
      for (int j = 0; j < NR; j++) if (m_ready[j]) w = j;
      a = req_addr[w*3 +: 3];
      m_wr_en = (R0Z && a == 0) ? 8'h00 : (8'd1 << a);
      m_wr_data = req_data[w*8 +: 8];
      if (R0Z && a == 0) m_err = 1'b1;
      m_ptr = (w + 1) % NR;
    end else begin
      m_wr_en = '0;
    end
  endtask

  // Drive one cycle of inputs, then advance the model across the next edge
  task automatic applyStimulus(input logic [2:0] v, input logic [8:0] a, input logic [23:0] d,
                               input logic c, input logic s);
    req_valid = v; req_addr = a; req_data = d; clr = c; stall = s;
    computeReady();
    @(posedge clk);
    last_grant = m_ready;
    #1;
    modelStep();
  endtask

  // Asynchronous reset in the middle of whatever is going on
  task automatic midReset();
    reset = 1'b0;
    #1;
    checkOutput("async_rst_wr_en", wr_en, 8'h00);
    checkOutput("async_rst_wr_data", wr_data, 8'h00);
    checkOutput("async_rst_busy", busy, 1'b1);
    checkOutput("async_rst_ready", req_ready, 3'b000);
    checkOutput("async_rst_err", err_r0, 1'b0);
    modelReset();
    p_valid = '0;
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Compare every DUT output against the model in the middle of each cycle
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("wr_en", wr_en, m_wr_en);
      checkOutput("wr_data", wr_data, m_wr_data);
      checkOutput("busy", busy, m_busy);
      checkOutput("err_r0", err_r0, m_err);
      checkOutput("req_ready", req_ready, m_ready);
    end
  end

  localparam logic [8:0]  ADDR123 = {3'd3, 3'd2, 3'd1};
  localparam logic [23:0] DATA123 = {8'h33, 8'h22, 8'h11};

  // Directed scenarios followed by randomized traffic
  initial begin
    modelReset();
    p_valid = '0;
    check_en = 1'b1;
    #2;
    checkOutput("reset_wr_en", wr_en, 8'h00);
    checkOutput("reset_busy", busy, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Initialisation walk with requests already pending
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b111, ADDR123, DATA123, 1'b0, 1'b0);
      checkOutput("init_wr_en", wr_en, 8'h01 << i);
    end
    checkOutput("init_last_data", wr_data, 8'hA5);
    checkOutput("init_done_busy", busy, 1'b0);

    // All three requesters valid: strict rotation 0,1,2
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3'b111, ADDR123, DATA123, 1'b0, 1'b0);
      checkOutput("rr_wr_en", wr_en, 8'h02 << (i % 3));
    end
    checkOutput("rr_wr_data", wr_data, 8'h33);

    // Collision on r5 from requesters 0 and 2
    applyStimulus(3'b101, {3'd5, 3'd0, 3'd5}, {8'h20, 8'h00, 8'h10}, 1'b0, 1'b0);
    checkOutput("coll1_wr_en", wr_en, 8'h20);
    checkOutput("coll1_wr_data", wr_data, 8'h10);
    applyStimulus(3'b100, {3'd5, 3'd0, 3'd5}, {8'h20, 8'h00, 8'h10}, 1'b0, 1'b0);
    checkOutput("coll2_wr_en", wr_en, 8'h20);
    checkOutput("coll2_wr_data", wr_data, 8'h20);

    // Stall for three cycles, then the grant resumes at requester 0
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'b111, ADDR123, DATA123, 1'b0, 1'b1);
      checkOutput("stall_wr_en", wr_en, 8'h00);
    end
    applyStimulus(3'b111, ADDR123, DATA123, 1'b0, 1'b0);
    checkOutput("post_stall_wr_en", wr_en, 8'h02);

    // clr with requests pending, then INIT, then requester 1 is next
    applyStimulus(3'b111, ADDR123, DATA123, 1'b1, 1'b0);
    checkOutput("clr_wr_en", wr_en, 8'h00);
    checkOutput("clr_busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b111, ADDR123, DATA123, 1'b0, 1'b0);
    end
    checkOutput("reinit_busy", busy, 1'b0);
    applyStimulus(3'b111, ADDR123, DATA123, 1'b0, 1'b0);
    checkOutput("post_clr_wr_en", wr_en, 8'h04);

    // Write to r0 from requester 0
    applyStimulus(3'b001, 9'd0, 24'h0000FF, 1'b0, 1'b0);
    checkOutput("r0_wr_en", wr_en, R0Z ? 8'h00 : 8'h01);
    checkOutput("r0_err", err_r0, R0Z ? 1'b1 : 1'b0);
    applyStimulus(3'b000, 9'd0, 24'h0, 1'b0, 1'b0);
    checkOutput("r0_err_sticky", err_r0, R0Z ? 1'b1 : 1'b0);
    applyStimulus(3'b000, 9'd0, 24'h0, 1'b1, 1'b0);
    checkOutput("r0_err_clr", err_r0, 1'b0);

    // Randomized traffic with occasional clr, stall and asynchronous reset
    last_grant = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic c;
      logic s;
      if (cyc % 700 == 699) begin
        midReset();
      end
      for (int i = 0; i < NR; i++) begin
        if (p_valid[i] && last_grant[i]) p_valid[i] = 1'b0;
        if (!p_valid[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            p_valid[i] = 1'b1;
            p_addr[i] = 3'($urandom_range(7, 0));
            p_data[i] = 8'($urandom_range(255, 0));
          end
        end else if ($urandom_range(15, 0) == 0) begin
          p_valid[i] = 1'b0;
        end
      end
      c = ($urandom_range(63, 0) == 0);
      s = ($urandom_range(7, 0) == 0);
      applyStimulus(p_valid, {p_addr[2], p_addr[1], p_addr[0]},
                    {p_data[2], p_data[1], p_data[0]}, c, s);
    end

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
